// File: rtl/ram_boot_loader_if.sv
// Signal bundle between ram_boot_loader (slave) and its host/RAM side (master).
interface ram_boot_loader_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic                  rx_valid_i;
  logic [7:0]            rx_data_i;
  logic                  rx_ready_o;
  logic                  mem_en_o;
  logic [3:0]            mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  modport master (
    output start_i, base_addr_i, rx_valid_i, rx_data_i,
    input  rx_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, error_o
  );

  modport slave (
    input  start_i, base_addr_i, rx_valid_i, rx_data_i,
    output rx_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/ram_boot_loader.sv
// Streams a length-prefixed byte payload from a host link into RAM as 32-bit words.
// Define RS5_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module ram_boot_loader #(
  parameter int MEM_WIDTH  = 1048576,
  parameter int ADDR_WIDTH = $clog2(MEM_WIDTH)
) (
  input logic              clk,
  input logic              reset,
  ram_boot_loader_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;

`ifdef RS5_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  mem_en_q, mem_en_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
`ifdef RS5_BOOT_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  logic        accept;
  logic [1:0]  lane;
  logic        last_byte;
  logic [31:0] word;
  logic [31:0] hdr_len;
  logic [32:0] hdr_end;
  logic [3:0]  lane_mask;

  always_comb begin
    accept    = bus.rx_valid_i && rx_ready_q;
    lane      = cnt_q[1:0];
    last_byte = (cnt_q + CW'(1)) == len_q[CW-1:0];
    // A new word starts from zero so unused lanes of a partial word read as 0.
    word      = (lane == 2'd0) ? 32'h0 : asm_q;
    word[{lane, 3'b000} +: 8] = bus.rx_data_i;
    hdr_len   = {bus.rx_data_i, len_q[31:8]};
    hdr_end   = 33'(base_q) + {1'b0, hdr_len};
    case (lane)
      2'd0:    lane_mask = 4'b0001;
      2'd1:    lane_mask = 4'b0011;
      2'd2:    lane_mask = 4'b0111;
      default: lane_mask = 4'b1111;
    endcase

    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    err_d      = err_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 4'b0000;
    mem_addr_d = '0;
    mem_data_d = 32'h0;
`ifdef RS5_BOOT_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          err_d = 1'b0;
          if (bus.base_addr_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            base_d  = bus.base_addr_i;
            len_d   = 32'h0;
            cnt_d   = '0;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (accept) begin
          len_d = hdr_len;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(3)) begin
            cnt_d = '0;
            asm_d = 32'h0;
`ifdef RS5_BOOT_CHECKSUM_EN
            chk_d = 8'h00;
`endif
            if (hdr_len == 32'd0) begin
`ifdef RS5_BOOT_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else if (hdr_end > 33'(MEM_WIDTH)) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d = word;
          cnt_d = cnt_q + CW'(1);
`ifdef RS5_BOOT_CHECKSUM_EN
          chk_d = chk_q ^ bus.rx_data_i;
`endif
          if (lane == 2'd3 || last_byte) begin
            mem_en_d   = 1'b1;
            mem_we_d   = lane_mask;
            mem_addr_d = base_q + ADDR_WIDTH'(cnt_q & ~CW'(3));
            mem_data_d = word;
          end
          if (last_byte) state_d = FLUSH;
        end
      end
      // The final write is on the bus during this state, so DONE never overlaps it.
      FLUSH: begin
`ifdef RS5_BOOT_CHECKSUM_EN
        state_d = CHK;
`else
        state_d = DONE;
`endif
      end
`ifdef RS5_BOOT_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (bus.rx_data_i != chk_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef RS5_BOOT_CHECKSUM_EN
    rx_ready_d = (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
`else
    rx_ready_d = (state_d == HDR) || (state_d == DATA);
`endif
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= 32'h0;
      cnt_q      <= '0;
      asm_q      <= 32'h0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 4'b0000;
      mem_addr_q <= '0;
      mem_data_q <= 32'h0;
`ifdef RS5_BOOT_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef RS5_BOOT_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Outputs are masked by reset so they read 0 from the first reset cycle onward.
  assign bus.rx_ready_o = rx_ready_q & ~reset;
  assign bus.busy_o     = busy_q & ~reset;
  assign bus.done_o     = done_q & ~reset;
  assign bus.error_o    = err_q & ~reset;
  assign bus.mem_en_o   = mem_en_q & ~reset;
  assign bus.mem_we_o   = mem_we_q & {4{~reset}};
  assign bus.mem_addr_o = mem_addr_q & {ADDR_WIDTH{~reset}};
  assign bus.mem_data_o = mem_data_q & {32{~reset}};
endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed-vector bench for ram_boot_loader with a 1 KiB target RAM.
module tb_ram_boot_loader;
  localparam int MW = 1024;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset;

  ram_boot_loader_if #(.ADDR_WIDTH(AW)) bus_if ();
  ram_boot_loader #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int bus_viol = 0;

  typedef struct {
    logic [9:0]  base;
    logic [31:0] n;
    bit          hdr;
    bit          lerr;
    bit          gaps;
    logic [63:0] pay;
    int          nw;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [3:0]  m0;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic [3:0]  m1;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t  wq[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: logs writes, flags non-zero idle bus and writes overlapping done.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.mem_en_o) begin
        wq.push_back('{bus_if.mem_addr_o, bus_if.mem_data_o, bus_if.mem_we_o});
        if (bus_if.done_o) begin
          bus_viol++;
          $display("FAIL bus_overlap: write at 0x%0h during done", bus_if.mem_addr_o);
        end
      end else if (bus_if.mem_we_o != 4'h0 || bus_if.mem_addr_o != '0 || bus_if.mem_data_o != 32'h0) begin
        bus_viol++;
        $display("FAIL bus_idle: we=0x%0h addr=0x%0h data=0x%0h, expected all 0",
                 bus_if.mem_we_o, bus_if.mem_addr_o, bus_if.mem_data_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit must_be_ready, input string tag);
    bit acc;
    bit first;
    acc   = 1'b0;
    first = 1'b1;
    bus_if.rx_valid_i = 1'b1;
    bus_if.rx_data_i  = b;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = bus_if.rx_ready_o;
      if (must_be_ready && first) check({tag, "_ready"}, 32'(acc), 32'd1);
      first = 1'b0;
      tick();
    end
    bus_if.rx_valid_i = 1'b0;
    check({tag, "_accepted"}, 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input logic exp_err);
    bit   seen;
    logic err;
    seen = 1'b0;
    err  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus_if.done_o) begin
        seen = 1'b1;
        err  = bus_if.error_o;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("error_at_done", 32'(err), 32'(exp_err));
    @(negedge clk);
    check("done_one_cycle", 32'(bus_if.done_o), 32'd0);
    check("idle_after_done", 32'(bus_if.busy_o), 32'd0);
    check("error_hold", 32'(bus_if.error_o), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input vec_t v, input logic [7:0] flip);
    int         npay;
    logic [7:0] xr;
    logic [7:0] b;
    logic       exp_err;
    exp_err = !v.hdr || v.lerr || (flip != 8'h00);
    wq.delete();
    check("idle_ready", 32'(bus_if.rx_ready_o), 32'd0);
    bus_if.start_i     = 1'b1;
    bus_if.base_addr_i = v.base;
    tick();
    bus_if.start_i = 1'b0;
    check("busy_after_start", 32'(bus_if.busy_o), 32'd1);
    if (v.hdr) begin
      check("error_cleared", 32'(bus_if.error_o), 32'd0);
      for (int k = 0; k < 4; k++) send_byte(v.n[8*k +: 8], 1'b1, "hdr");
    end
    npay = (v.hdr && !v.lerr) ? int'(v.n) : 0;
    xr   = 8'h00;
    for (int k = 0; k < npay; k++) begin
      if (v.gaps && k > 0) tick();
      if (v.gaps && k == 2) begin
        bus_if.start_i     = 1'b1;
        bus_if.base_addr_i = 10'h200;
      end
      b  = v.pay[8*k +: 8];
      xr = xr ^ b;
      send_byte(b, 1'b1, "pay");
      bus_if.start_i = 1'b0;
    end
`ifdef RS5_BOOT_CHECKSUM_EN
    if (v.hdr && !v.lerr) send_byte(xr ^ flip, 1'b0, "chk");
`endif
    wait_done(exp_err);
    check("num_writes", 32'(wq.size()), 32'(v.nw));
    if (v.nw > 0 && wq.size() > 0) begin
      check("w0_addr", 32'(wq[0].a), 32'(v.a0));
      check("w0_data", wq[0].d, v.d0);
      check("w0_mask", 32'(wq[0].m), 32'(v.m0));
    end
    if (v.nw > 1 && wq.size() > 1) begin
      check("w1_addr", 32'(wq[1].a), 32'(v.a1));
      check("w1_data", wq[1].d, v.d1);
      check("w1_mask", 32'(wq[1].m), 32'(v.m1));
    end
    $display("[TB] load base=0x%0h n=0x%0h writes=%0d expected_err=%0b", v.base, v.n, wq.size(), exp_err);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{10'h100, 32'd8, 1'b1, 1'b0, 1'b0, 64'h1817161514131211, 2, 10'h100, 32'h14131211, 4'hF, 10'h104, 32'h18171615, 4'hF};
    vecs[1]  = '{10'h000, 32'd5, 1'b1, 1'b0, 1'b0, 64'h000000EEDDCCBBAA, 2, 10'h000, 32'hDDCCBBAA, 4'hF, 10'h004, 32'h000000EE, 4'h1};
    vecs[2]  = '{10'h3FC, 32'd8, 1'b1, 1'b1, 1'b0, 64'h0, 0, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0};
    vecs[3]  = '{10'h102, 32'd0, 1'b0, 1'b0, 1'b0, 64'h0, 0, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0};
    vecs[4]  = '{10'h020, 32'd4, 1'b1, 1'b0, 1'b1, 64'h04030201, 1, 10'h020, 32'h04030201, 4'hF, 10'h0, 32'h0, 4'h0};
    vecs[5]  = '{10'h040, 32'd0, 1'b1, 1'b0, 1'b0, 64'h0, 0, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0};
    vecs[6]  = '{10'h3F8, 32'd8, 1'b1, 1'b0, 1'b0, 64'h2827262524232221, 2, 10'h3F8, 32'h24232221, 4'hF, 10'h3FC, 32'h28272625, 4'hF};
    vecs[7]  = '{10'h3FC, 32'd5, 1'b1, 1'b1, 1'b0, 64'h0, 0, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0};
    vecs[8]  = '{10'h080, 32'd6, 1'b1, 1'b0, 1'b0, 64'h0000A6A5A4A3A2A1, 2, 10'h080, 32'hA4A3A2A1, 4'hF, 10'h084, 32'h0000A6A5, 4'h3};
    vecs[9]  = '{10'h084, 32'd3, 1'b1, 1'b0, 1'b1, 64'h112233, 1, 10'h084, 32'h00112233, 4'h7, 10'h0, 32'h0, 4'h0};
    vecs[10] = '{10'h010, 32'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 64'h0, 0, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0};
    vecs[11] = '{10'h3FC, 32'd1, 1'b1, 1'b0, 1'b0, 64'h5A, 1, 10'h3FC, 32'h0000005A, 4'h1, 10'h0, 32'h0, 4'h0};

    reset              = 1'b1;
    bus_if.start_i     = 1'b0;
    bus_if.base_addr_i = '0;
    bus_if.rx_valid_i  = 1'b0;
    bus_if.rx_data_i   = 8'h00;
    tick();
    tick();
    @(negedge clk);
    check("reset_ctl_zero", 32'({bus_if.rx_ready_o, bus_if.mem_en_o, bus_if.mem_we_o, bus_if.busy_o, bus_if.done_o, bus_if.error_o}), 32'd0);
    check("reset_bus_zero", 32'(bus_if.mem_addr_o) | bus_if.mem_data_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("post_reset_busy", 32'(bus_if.busy_o), 32'd0);

    for (int i = 0; i < 12; i++) run_load(vecs[i], 8'h00);

    // Reset after three payload bytes: partial word dropped, outputs forced low.
    wq.delete();
    bus_if.start_i     = 1'b1;
    bus_if.base_addr_i = 10'h100;
    tick();
    bus_if.start_i = 1'b0;
    send_byte(8'h08, 1'b1, "rst_hdr");
    for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1, "rst_hdr");
    for (int k = 0; k < 3; k++) send_byte(8'h11 + 8'(k), 1'b1, "rst_pay");
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ctl_zero", 32'({bus_if.rx_ready_o, bus_if.mem_en_o, bus_if.mem_we_o, bus_if.busy_o, bus_if.done_o, bus_if.error_o}), 32'd0);
    check("midreset_bus_zero", 32'(bus_if.mem_addr_o) | bus_if.mem_data_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("midreset_no_write", 32'(wq.size()), 32'd0);
    $display("[TB] reset mid-load base=0x100 writes=%0d", wq.size());
    v = '{10'h100, 32'd4, 1'b1, 1'b0, 1'b0, 64'h88776655, 1, 10'h100, 32'h88776655, 4'hF, 10'h0, 32'h0, 4'h0};
    run_load(v, 8'h00);

`ifdef RS5_BOOT_CHECKSUM_EN
    v = '{10'h010, 32'd2, 1'b1, 1'b0, 1'b0, 64'h0201, 1, 10'h010, 32'h00000201, 4'h3, 10'h0, 32'h0, 4'h0};
    run_load(v, 8'h00);
    run_load(v, 8'h03);
`endif

    check("bus_protocol_violations", 32'(bus_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_boot_loader.md
RAM_BOOT_LOADER -- requirements
Module: ram_boot_loader

Interface
REQ-001 Parameter MEM_WIDTH, default 1048576, SHALL be the target RAM size in bytes.
REQ-002 Parameter ADDR_WIDTH, default $clog2(MEM_WIDTH), SHALL be the byte-address width.
REQ-003 Clock and reset SHALL be: one clock, reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  pulse; starts a load when the block is idle.
REQ-007 base_addr_i  input  ADDR_WIDTH  byte address of the first payload byte; sampled on an accepted start.
REQ-008 rx_valid_i / rx_data_i  input  1 / 8  byte stream from the host link.
REQ-009 rx_ready_o  output  1  byte accepted when rx_valid_i && rx_ready_o.
REQ-010 mem_en_o / mem_we_o  output  1 / 4  RAM port enable and byte write mask.
REQ-011 mem_addr_o / mem_data_o  output  ADDR_WIDTH / 32  RAM word address (byte units) and write data.
REQ-012 busy_o / done_o / error_o  output  1 / 1 / 1  load active; one-cycle completion pulse; error flag.

Function
REQ-013 The FSM SHALL have the states IDLE, HDR, DATA, FLUSH, CHK and DONE; CHK exists only when the Configuration macro is defined.
REQ-014 IDLE with start_i=1: if base_addr_i[1:0]!=0, go to DONE with error_o=1; otherwise latch the base address and go to HDR. start_i SHALL be ignored in every other state.
REQ-015 HDR: accept 4 bytes that form a little-endian 32-bit length N.
- N=0: go to DONE with no writes.
- base+N > MEM_WIDTH: go to DONE with error_o=1 and no writes.
- Otherwise: go to DATA.
REQ-016 DATA: pack accepted bytes little-endian into a 32-bit assembly register, with byte k of the payload in lane k mod 4.
REQ-017 When the 4th byte of a word is accepted, the cycle after SHALL drive the word for exactly one cycle:
- mem_en_o=1, mem_we_o=4'b1111
- mem_addr_o = base + 4*word_index
- mem_data_o = the assembled word
REQ-018 rx_ready_o SHALL stay 1 in HDR, DATA and CHK, including write cycles: sustained one byte per cycle, no stalls.
REQ-019 After payload byte N is accepted with N mod 4 = r != 0, go to FLUSH and issue one write next cycle.
- Mask: r=1 -> 0001, r=2 -> 0011, r=3 -> 0111.
- Unused data lanes SHALL be 0.
REQ-020 After the final write, go to CHK if the macro is enabled, else to DONE.
REQ-021 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-022 In all cycles without a write: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
REQ-023 rx_ready_o SHALL be 0 in IDLE, FLUSH and DONE.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 error_o SHALL be set with entry to DONE and hold until the next accepted start_i clears it.
REQ-026 Address arithmetic SHALL be ADDR_WIDTH wide; the length check SHALL use 33-bit arithmetic so that it cannot wrap.

Reset
REQ-027 Reset SHALL force IDLE and clear the assembly register, counters and error_o.
REQ-028 While reset is asserted, every output SHALL be 0.
REQ-029 Reset during a load SHALL discard any partial word and issue no write in the cycle after reset.

Configuration
REQ-030 Macro RS5_BOOT_CHECKSUM_EN SHALL select checksum support.
- Defined: after the payload, CHK accepts one byte; it must equal the XOR of all N payload bytes, and N=0 expects 0x00.
- Mismatch: set error_o in DONE; writes already issued remain.
- The length-error path of REQ-015 skips CHK.
REQ-031 Without the macro: no CHK state and no checksum byte; DONE follows the last write directly.

Verification
REQ-032 base=0x100, header 08 00 00 00, bytes 11..18 back-to-back -> writes 0x14131211@0x100 and 0x18171615@0x104 with we=1111, then done_o=1, error_o=0.
REQ-033 base=0x0, N=5, bytes AA BB CC DD EE -> 0xDDCCBBAA@0x0 we=1111, then 0x000000EE@0x4 we=0001.
REQ-034 MEM_WIDTH=1024, base=0x3FC, N=8 -> no mem_en_o pulse, done_o with error_o=1. base=0x102 -> immediate error.
REQ-035 N=4 stream with rx_valid_i toggling 1,0,1,0 -> same single write; start_i pulsed mid-load is ignored.
REQ-036 reset asserted after 3 payload bytes -> no write, outputs 0. A new load to the same base then writes correct data.
REQ-037 RS5_BOOT_CHECKSUM_EN, N=2, bytes 01 02, chk 03 -> error_o=0. The same stream with chk 00 -> error_o=1, and the write to base still occurs.
